// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and load/store requests onto one byte-wide
// synchronous RAM and serialises 1/2/4-byte accesses into byte cycles.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              i_valid,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic              i_rsp_valid,
  output logic [31:0]       i_rsp_inst,
  output logic [ADDR_W-1:0] i_rsp_addr,
  input  logic              d_valid,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [1:0]        d_size,
  input  logic              d_signed,
  output logic              d_ready,
  output logic              d_rsp_valid,
  output logic [31:0]       d_rsp_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_dout,
  output logic              ram_we,
  input  logic [7:0]        ram_din,
  output logic [1:0]        o_dbg_state
);

  localparam int CW = $clog2(RD_LAT + 6);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [CW-1:0] TWO_C   = CW'(2);
  localparam logic [CW-1:0] FOUR_C  = CW'(4);
  localparam logic [CW-1:0] LAT_C   = CW'(RD_LAT);
  localparam logic [CW-1:0] LAT1_C  = CW'(RD_LAT + 1);
  localparam logic [SW-1:0] SONE_C  = SW'(1);
  localparam logic [SW-1:0] STARV_C = SW'(STARVE_MAX);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic                r_live;
  logic [SW-1:0]       r_starve;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic                r_we;
  logic                r_signed;
  logic                r_is_fetch;
  logic                r_squash;
  logic [CW-1:0]       r_n;
  logic [CW-1:0]       r_cyc;
  logic [31:0]         r_data;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic [7:0]          r_ram_dout;
  logic                r_ram_we;
  logic                r_i_rsp_valid;
  logic [31:0]         r_i_rsp_inst;
  logic [ADDR_W-1:0]   r_i_rsp_addr;
  logic                r_d_rsp_valid;
  logic [31:0]         r_d_rsp_data;

  logic                w_idle;
  logic                w_d_ready;
  logic                w_i_ready;
  logic                w_d_go;
  logic                w_i_go;
  logic [CW-1:0]       w_n_req;
  logic                w_flush_hit;
  logic                w_final;
  logic                w_issue;
  logic                w_squash;
  logic                w_store_done;
  logic                w_read_done;
  logic                w_rsp_en;
  logic [CW-1:0]       w_samp_idx;
  logic                w_sample;
  logic [31:0]         w_rdata;
  logic [31:0]         w_ext;
  logic [7:0]          w_wbyte;

  // Handshake: a request transfers on the rising edge where valid & ready are
  // both high; ready is only offered in IDLE and never depends on a later edge.
  // Data wins the tie unless a waiting fetch has already lost STARVE_MAX times.
  assign w_idle    = (r_state == S_IDLE);
  assign w_d_ready = r_live & w_idle & ~(i_valid & ~flush & (r_starve == STARV_C));
  assign w_i_ready = r_live & w_idle & ~flush & ~(d_valid & w_d_ready);
  assign w_d_go    = d_valid & w_d_ready;
  assign w_i_go    = i_valid & w_i_ready;

  assign w_flush_hit = flush & r_is_fetch & ~w_idle;
  assign w_final     = (r_cyc == r_n + LAT_C);
  assign w_rsp_en    = ~r_squash & ~w_flush_hit;

  always_comb begin
    w_n_req = FOUR_C;
    case (d_size)
      2'd0:    w_n_req = ONE_C;
      2'd1:    w_n_req = TWO_C;
      default: w_n_req = FOUR_C;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_issue      = 1'b0;
    w_squash     = 1'b0;
    w_store_done = 1'b0;
    w_read_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_d_go)      w_state_next = (!d_we && d_size == 2'd0) ? S_DRAIN : S_ISSUE;
        else if (w_i_go) w_state_next = S_ISSUE;
      end
      S_ISSUE: begin
        if (r_we) begin
          if (r_cyc == r_n) begin
            w_store_done = 1'b1;
            w_state_next = S_IDLE;
          end else begin
            w_issue = 1'b1;
          end
        end else if (w_flush_hit) begin
          w_squash     = 1'b1;
          w_state_next = S_DRAIN;
        end else begin
          w_issue = 1'b1;
          if (r_cyc == r_n - ONE_C) w_state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_flush_hit) w_squash = 1'b1;
        if (w_final) begin
          w_read_done  = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Byte k issued at edge t0+k comes back on edge t0+k+RD_LAT+1.
  assign w_samp_idx = r_cyc - LAT1_C;
  assign w_sample   = ~w_idle & ~r_we & (r_cyc >= LAT1_C) & (w_samp_idx < r_n);

  always_comb begin
    w_rdata = r_data;
    if (w_sample) begin
      case (w_samp_idx[1:0])
        2'd0:    w_rdata[7:0]   = ram_din;
        2'd1:    w_rdata[15:8]  = ram_din;
        2'd2:    w_rdata[23:16] = ram_din;
        default: w_rdata[31:24] = ram_din;
      endcase
    end
  end

  always_comb begin
    w_ext = w_rdata;
    if (r_n == ONE_C)      w_ext = {{24{r_signed & w_rdata[7]}}, w_rdata[7:0]};
    else if (r_n == TWO_C) w_ext = {{16{r_signed & w_rdata[15]}}, w_rdata[15:0]};
  end

  always_comb begin
    w_wbyte = r_wdata[7:0];
    case (r_cyc[1:0])
      2'd1:    w_wbyte = r_wdata[15:8];
      2'd2:    w_wbyte = r_wdata[23:16];
      2'd3:    w_wbyte = r_wdata[31:24];
      default: w_wbyte = r_wdata[7:0];
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_starve <= '0;
    end else if (!i_valid || w_i_go) begin
      r_starve <= '0;
    end else if (w_d_go && r_starve != STARV_C) begin
      r_starve <= r_starve + SONE_C;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_live        <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_we          <= 1'b0;
      r_signed      <= 1'b0;
      r_is_fetch    <= 1'b0;
      r_squash      <= 1'b0;
      r_n           <= '0;
      r_cyc         <= '0;
      r_data        <= '0;
      r_ram_addr    <= '0;
      r_ram_dout    <= '0;
      r_ram_we      <= 1'b0;
      r_i_rsp_valid <= 1'b0;
      r_i_rsp_inst  <= '0;
      r_i_rsp_addr  <= '0;
      r_d_rsp_valid <= 1'b0;
      r_d_rsp_data  <= '0;
    end else begin
      r_live        <= 1'b1;
      r_i_rsp_valid <= 1'b0;
      r_d_rsp_valid <= 1'b0;
      if (w_d_go) begin
        r_addr     <= d_addr;
        r_wdata    <= d_wdata;
        r_we       <= d_we;
        r_signed   <= d_signed;
        r_is_fetch <= 1'b0;
        r_squash   <= 1'b0;
        r_n        <= w_n_req;
        r_cyc      <= ONE_C;
        r_data     <= '0;
        r_ram_addr <= d_addr;
        r_ram_we   <= d_we;
        r_ram_dout <= d_wdata[7:0];
      end else if (w_i_go) begin
        r_addr     <= i_addr;
        r_wdata    <= '0;
        r_we       <= 1'b0;
        r_signed   <= 1'b0;
        r_is_fetch <= 1'b1;
        r_squash   <= 1'b0;
        r_n        <= FOUR_C;
        r_cyc      <= ONE_C;
        r_data     <= '0;
        r_ram_addr <= i_addr;
        r_ram_we   <= 1'b0;
        r_ram_dout <= '0;
      end else if (!w_idle) begin
        r_cyc  <= r_cyc + ONE_C;
        r_data <= w_rdata;
        if (w_issue) begin
          r_ram_addr <= r_addr + ADDR_W'(r_cyc);
          r_ram_dout <= w_wbyte;
        end
        // A squash mid-issue shrinks the transfer to the bytes already on the
        // bus, so the drain only waits out reads that are really in flight.
        if (w_squash) begin
          r_squash <= 1'b1;
          if (r_state == S_ISSUE) r_n <= r_cyc;
        end
        if (w_store_done) begin
          r_ram_we      <= 1'b0;
          r_d_rsp_valid <= 1'b1;
          r_d_rsp_data  <= '0;
        end
        if (w_read_done && r_is_fetch && w_rsp_en) begin
          r_i_rsp_valid <= 1'b1;
          r_i_rsp_inst  <= w_rdata;
          r_i_rsp_addr  <= r_addr;
        end
        if (w_read_done && !r_is_fetch) begin
          r_d_rsp_valid <= 1'b1;
          r_d_rsp_data  <= w_ext;
        end
      end
    end
  end

  assign i_ready     = w_i_ready;
  assign d_ready     = w_d_ready;
  assign i_rsp_valid = r_i_rsp_valid;
  assign i_rsp_inst  = r_i_rsp_inst;
  assign i_rsp_addr  = r_i_rsp_addr;
  assign d_rsp_valid = r_d_rsp_valid;
  assign d_rsp_data  = r_d_rsp_data;
  assign ram_addr    = r_ram_addr;
  assign ram_dout    = r_ram_dout;
  assign ram_we      = r_ram_we;
  assign o_dbg_state = r_state;

endmodule
